// File: rtl/uart_tx_frame_if.sv
// Byte-stream handshake into the UART transmitter.
//   data      : byte offered by the producer
//   dataValid : producer has a byte this cycle
//   dataReady : transmitter FIFO can take a byte this cycle
interface uart_tx_frame_if;
    logic [7:0] data;
    logic       dataValid;
    logic       dataReady;

    modport master (
        output data,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  data,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter with a byte FIFO in front of an 8N1/8N2 framer.
//   clock     : single clock, rising edge
//   reset     : synchronous, active-high
//   bus       : byte handshake (data / dataValid / dataReady)
//   tx        : registered serial line, idle high
//   busy      : frame in progress or bytes still queued
//   fifoCount : bytes queued, not counting the one on the line
module uart_tx_frame #(
    parameter int unsigned ClockFrequency = 1000000,
    parameter int unsigned BaudRate       = 9600,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned StopBits       = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    uart_tx_frame_if.slave               bus,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FifoDepth):0]   fifoCount
);

    localparam int unsigned BitTicks = ClockFrequency / BaudRate;
    localparam int unsigned TickW    = (BitTicks > 1) ? $clog2(BitTicks) : 1;
    localparam int unsigned PtrW     = $clog2(FifoDepth);
    localparam int unsigned CntW     = PtrW + 1;

    // Parameter sanity, rejected at elaboration
    if (BitTicks < 2) begin : g_bad_bit_ticks
        $fatal(1, "uart_tx_frame: ClockFrequency/BaudRate must be at least 2");
    end
    if (FifoDepth < 2 || FifoDepth > 16 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_tx_frame: FifoDepth must be a power of two in 2..16");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $fatal(1, "uart_tx_frame: StopBits must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TickW-1:0]  tick;
    logic [TickW-1:0]  tick_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        sr;
    logic [7:0]        sr_next;
    logic              tx_next;
    logic              pop;
    logic              push;
    logic              ready;
    logic              bit_end;

    logic [7:0]        mem [FifoDepth];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [CntW-1:0]   count;

    // Handshake: ready depends only on the registered count
    assign ready         = (count != CntW'(FifoDepth));
    assign push          = bus.dataValid && ready;
    assign bus.dataReady = ready;
    assign fifoCount     = count;
    assign busy          = (state != IDLE) || (count != '0);
    assign bit_end       = (tick == TickW'(BitTicks - 1));

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath-next logic; a frame start always pops the FIFO head
    always_comb begin
        state_next = state;
        tick_next  = tick;
        bit_next   = bit_idx;
        sr_next    = sr;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = START;
                    pop        = 1'b1;
                    sr_next    = mem[rd_ptr];
                    tick_next  = '0;
                    bit_next   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tick_next  = '0;
                    bit_next   = '0;
                end else begin
                    tick_next = tick + TickW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        sr_next  = {1'b0, sr[7:1]};
                    end
                end else begin
                    tick_next = tick + TickW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    tick_next = '0;
                    if (bit_idx == 3'(StopBits - 1)) begin
                        // Back-to-back frames: next start bit follows the last stop cycle
                        if (count != '0) begin
                            state_next = START;
                            pop        = 1'b1;
                            sr_next    = mem[rd_ptr];
                            bit_next   = '0;
                        end else begin
                            state_next = IDLE;
                            bit_next   = '0;
                        end
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    tick_next = tick + TickW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: line level for the state being entered (sr[0] is the current data bit)
    always_comb begin
        tx_next = 1'b1;
        if (state_next == DATA) begin
            tx_next = sr_next[0];
        end else if (state_next == START) begin
            tx_next = 1'b0;
        end
    end

    // Bit timing, shift register and registered line
    always_ff @(posedge clock) begin
        if (reset) begin
            tick    <= '0;
            bit_idx <= '0;
            sr      <= '0;
            tx      <= 1'b1;
        end else begin
            tick    <= tick_next;
            bit_idx <= bit_next;
            sr      <= sr_next;
            tx      <= tx_next;
        end
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (1 and 2 stop bits) at 10 clocks per bit,
// checked every cycle against a frame-position reference model plus a line decoder.
module tb_uart_tx_frame;

    localparam int Depth = 4;
    localparam int BitT  = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] din [2];
    logic       dv  [2];

    uart_tx_frame_if bus0 ();
    uart_tx_frame_if bus1 ();

    assign bus0.data      = din[0];
    assign bus0.dataValid = dv[0];
    assign bus1.data      = din[1];
    assign bus1.dataValid = dv[1];

    logic       tx0, tx1, busy0, busy1;
    logic [2:0] cnt0, cnt1;

    uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .FifoDepth(4), .StopBits(1)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .tx(tx0), .busy(busy0), .fifoCount(cnt0));

    uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .FifoDepth(4), .StopBits(2)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .tx(tx1), .busy(busy1), .fifoCount(cnt1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue plus position inside the current frame (-1 = idle)
    int         pos    [2];
    logic [7:0] cur    [2];
    logic [7:0] mq     [2][$];
    logic [7:0] sent_q [2][$];
    logic [7:0] rx_log [2][$];
    int         rx_cnt [2];
    logic [7:0] rx_sh  [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flen(input int d);
        return (d == 0) ? (10 * BitT) : (11 * BitT);
    endfunction

    function automatic logic exp_tx(input int d);
        int b;
        if (pos[d] < 0) return 1'b1;
        b = pos[d] / BitT;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[d][b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input int d, input logic rst_s, input logic dv_s, input logic [7:0] din_s);
        logic acc;
        if (rst_s) begin
            mq[d].delete();
            sent_q[d].delete();
            pos[d] = -1;
            return;
        end
        acc = dv_s && (mq[d].size() < Depth);
        if (pos[d] < 0 || pos[d] == flen(d) - 1) begin
            if (mq[d].size() > 0) begin
                cur[d] = mq[d].pop_front();
                sent_q[d].push_back(cur[d]);
                pos[d] = 0;
            end else begin
                pos[d] = -1;
            end
        end else begin
            pos[d]++;
        end
        if (acc) mq[d].push_back(din_s);
    endtask

    task automatic compare_outputs(input int d);
        logic       t, b, r;
        logic [2:0] c;
        t = (d == 0) ? tx0 : tx1;
        b = (d == 0) ? busy0 : busy1;
        c = (d == 0) ? cnt0 : cnt1;
        r = (d == 0) ? bus0.dataReady : bus1.dataReady;
        check_val($sformatf("d%0d tx", d), 32'(t), 32'(exp_tx(d)));
        check_val($sformatf("d%0d busy", d), 32'(b), 32'(pos[d] >= 0 || mq[d].size() != 0));
        check_val($sformatf("d%0d fifoCount", d), 32'(c), 32'(mq[d].size()));
        check_val($sformatf("d%0d dataReady", d), 32'(r), 32'(mq[d].size() != Depth));
    endtask

    // Line decoder: samples mid-bit and compares with the byte the model launched
    task automatic decode(input int d, input logic rst_s);
        logic       t;
        logic [7:0] e;
        t = (d == 0) ? tx0 : tx1;
        if (rst_s) begin
            rx_cnt[d] = -1;
            return;
        end
        if (rx_cnt[d] >= 0) rx_cnt[d]++;
        if (rx_cnt[d] == flen(d)) rx_cnt[d] = -1;
        if (rx_cnt[d] < 0 && t == 1'b0) rx_cnt[d] = 0;
        if (rx_cnt[d] >= 15 && rx_cnt[d] <= 85 && rx_cnt[d] % 10 == 5)
            rx_sh[d][(rx_cnt[d] - 15) / 10] = t;
        if (rx_cnt[d] >= 95 && rx_cnt[d] % 10 == 5)
            check_val($sformatf("d%0d stop bit", d), 32'(t), 32'd1);
        if (rx_cnt[d] == 95) begin
            check_val($sformatf("d%0d rx frame expected", d), 32'(sent_q[d].size() > 0), 32'd1);
            if (sent_q[d].size() > 0) begin
                e = sent_q[d].pop_front();
                check_val($sformatf("d%0d rx byte", d), 32'(rx_sh[d]), 32'(e));
            end
            rx_log[d].push_back(rx_sh[d]);
        end
    endtask

    task automatic step();
        logic rs;
        @(posedge clock);
        rs = reset;
        for (int d = 0; d < 2; d++) model_edge(d, reset, dv[d], din[d]);
        #1;
        for (int d = 0; d < 2; d++) begin
            compare_outputs(d);
            decode(d, rs);
        end
    endtask

    task automatic wait_idle(input int d, input int max_cycles);
        int n;
        n = 0;
        while (((d == 0) ? busy0 : busy1) && n < max_cycles) begin
            step();
            n++;
        end
        check_val($sformatf("d%0d drain", d), 32'((d == 0) ? busy0 : busy1), 32'd0);
    endtask

    initial begin
        logic [9:0]   pat;
        logic [199:0] line;
        logic [7:0]   g1, g2, nxt, b0, b1, b2, b3;
        logic [7:0]   wr [10];
        logic [7:0]   exp_list [$];
        logic         rdy;
        int           acc_n, six_at, idx;

        for (int d = 0; d < 2; d++) begin
            pos[d] = -1; rx_cnt[d] = -1; cur[d] = '0; rx_sh[d] = '0;
            din[d] = '0; dv[d] = 1'b0;
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_val("reset tx", 32'(tx0), 32'd1);
        check_val("reset busy", 32'(busy0), 32'd0);
        check_val("reset fifoCount", 32'(cnt0), 32'd0);
        check_val("reset dataReady", 32'(bus0.dataReady), 32'd1);
        step();

        // Single 0x55 frame from idle
        rx_log[0].delete();
        din[0] = 8'h55; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        pat = 10'b1010101010;
        for (int k = 1; k <= 100; k++) begin
            step();
            check_val("55 line bit", 32'(tx0), 32'(pat[(k-1)/10]));
            if (k == 100) check_val("55 busy last cycle", 32'(busy0), 32'd1);
        end
        step();
        check_val("55 busy after frame", 32'(busy0), 32'd0);
        check_val("55 line idle", 32'(tx0), 32'd1);
        check_val("55 rx count", 32'(rx_log[0].size()), 32'd1);
        if (rx_log[0].size() > 0) check_val("55 rx byte", 32'(rx_log[0][0]), 32'h55);

        // Back-to-back 0xA5, 0x3C
        din[0] = 8'hA5; dv[0] = 1'b1;
        step();
        din[0] = 8'h3C;
        step();
        dv[0] = 1'b0;
        line[0] = tx0;
        for (int k = 2; k <= 200; k++) begin
            step();
            line[k-1] = tx0;
        end
        for (int j = 0; j < 8; j++) begin
            g1[j] = line[15 + 10*j];
            g2[j] = line[115 + 10*j];
        end
        check_val("b2b start1", 32'(line[0]), 32'd0);
        check_val("b2b stop1", 32'(line[99]), 32'd1);
        check_val("b2b start2 contiguous", 32'(line[100]), 32'd0);
        check_val("b2b byte1", 32'(g1), 32'hA5);
        check_val("b2b byte2", 32'(g2), 32'h3C);
        step();
        check_val("b2b busy after", 32'(busy0), 32'd0);

        // Held dataValid into a slow drain
        rx_log[0].delete();
        nxt = 8'h00; acc_n = 0; six_at = 0;
        din[0] = nxt; dv[0] = 1'b1;
        for (int k = 1; k <= 200 && acc_n < 6; k++) begin
            rdy = bus0.dataReady;
            step();
            if (rdy) begin
                acc_n++;
                if (acc_n == 5) begin
                    check_val("fill fifoCount", 32'(cnt0), 32'd4);
                    check_val("fill dataReady", 32'(bus0.dataReady), 32'd0);
                end
                if (acc_n == 6) six_at = k;
                nxt = nxt + 8'd1;
                din[0] = nxt;
            end
        end
        dv[0] = 1'b0;
        check_val("sixth accept cycle", 32'(six_at), 32'd103);
        wait_idle(0, 800);
        check_val("drain rx count", 32'(rx_log[0].size()), 32'd6);
        for (int i = 0; i < rx_log[0].size() && i < 6; i++)
            check_val("drain order", 32'(rx_log[0][i]), 32'(i));

        // Reset at cycle 35 of a frame with two bytes queued
        din[0] = 8'h11; dv[0] = 1'b1; step();
        din[0] = 8'h22; step();
        din[0] = 8'h33; step();
        dv[0] = 1'b0;
        check_val("pre-reset fifoCount", 32'(cnt0), 32'd2);
        for (int k = 3; k <= 34; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("abort tx", 32'(tx0), 32'd1);
        check_val("abort busy", 32'(busy0), 32'd0);
        check_val("abort fifoCount", 32'(cnt0), 32'd0);
        check_val("abort dataReady", 32'(bus0.dataReady), 32'd1);
        for (int k = 0; k < 200; k++) begin
            step();
            check_val("abort line high", 32'(tx0), 32'd1);
        end

        // Two stop bits, 0xFF
        din[1] = 8'hFF; dv[1] = 1'b1;
        step();
        dv[1] = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            step();
            check_val("ff2 line", 32'(tx1), (k <= 10) ? 32'd0 : 32'd1);
            if (k == 110) check_val("ff2 busy last cycle", 32'(busy1), 32'd1);
        end
        step();
        check_val("ff2 busy after", 32'(busy1), 32'd0);

        // Push during pop at fifoCount=2, then a wrapping run of 10 bytes
        rx_log[0].delete();
        exp_list.delete();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        exp_list.push_back(b0); exp_list.push_back(b1);
        exp_list.push_back(b2); exp_list.push_back(b3);
        din[0] = b0; dv[0] = 1'b1; step();
        din[0] = b1; step();
        din[0] = b2; step();
        dv[0] = 1'b0;
        check_val("pp fifoCount before", 32'(cnt0), 32'd2);
        for (int k = 3; k <= 100; k++) step();
        din[0] = b3; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        check_val("pp fifoCount kept", 32'(cnt0), 32'd2);
        check_val("pp new start bit", 32'(tx0), 32'd0);
        for (int i = 0; i < 10; i++) begin
            wr[i] = 8'($urandom);
            exp_list.push_back(wr[i]);
        end
        idx = 0;
        din[0] = wr[0]; dv[0] = 1'b1;
        for (int k = 0; k < 2000 && idx < 10; k++) begin
            rdy = bus0.dataReady;
            step();
            if (rdy) begin
                idx++;
                if (idx < 10) din[0] = wr[idx];
            end
        end
        dv[0] = 1'b0;
        check_val("wrap all accepted", 32'(idx), 32'd10);
        wait_idle(0, 2000);
        check_val("wrap rx count", 32'(rx_log[0].size()), 32'(exp_list.size()));
        for (int i = 0; i < rx_log[0].size() && i < exp_list.size(); i++)
            check_val("wrap order", 32'(rx_log[0][i]), 32'(exp_list[i]));

        // Random traffic on both instances with occasional resets
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 2; d++) begin
                dv[d]  = ($urandom_range(0, 99) < ((k < 1500) ? 8 : 60));
                din[d] = 8'($urandom);
            end
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        dv[0] = 1'b0; dv[1] = 1'b0;
        wait_idle(0, 1500);
        wait_idle(1, 1500);
        check_val("final d0 launched all", 32'(sent_q[0].size()), 32'd0);
        check_val("final d1 launched all", 32'(sent_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter ClockFrequency, default 1000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 9600, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter FifoDepth, default 4, meaning byte FIFO depth; power of two, from 2 to 16.
REQ-004 SHALL have parameter StopBits, default 1, meaning stop bits per frame; 1 or 2.
REQ-005 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port data  input  8  byte to transmit.
REQ-008 SHALL have port dataValid  input  1  data is valid this cycle.
REQ-009 SHALL have port dataReady  output  1  FIFO can accept a byte this cycle.
REQ-010 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-011 SHALL have port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-012 SHALL have port fifoCount  output  $clog2(FifoDepth)+1  number of bytes queued, excluding the byte in flight.

Function
REQ-013 SHALL define BitTicks = ClockFrequency/BaudRate using integer division; BitTicks < 2 SHALL be a fatal elaboration error.
REQ-014 SHALL hold every line bit for exactly BitTicks clock cycles, using an internal counter of 0..BitTicks-1.
REQ-015 SHALL transmit each frame as: start bit (0), data[0]..data[7] (LSB first), then StopBits stop bits (1); frame length SHALL be (9+StopBits)*BitTicks cycles.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 SHALL make these FSM transitions:
- IDLE->START when the FIFO is non-empty.
- START->DATA after BitTicks cycles.
- DATA->STOP after 8 bit periods; bit index runs 0..7.
- At the end of the last stop-bit cycle: STOP->START if the FIFO is non-empty, else STOP->IDLE.
REQ-018 SHALL pop the FIFO head into the shift register on the same edge that enters START, and drive tx low on that edge.
REQ-019 SHALL have latency: byte accepted at edge N, FSM in IDLE, FIFO empty -> tx low starting at edge N+1.
REQ-020 SHALL send back-to-back frames contiguously, with no idle cycles between the last stop bit and the next start bit.
REQ-021 SHALL accept a byte on an edge only when dataValid=1 and dataReady=1.
REQ-022 SHALL drive dataReady = (fifoCount != FifoDepth), combinationally from registered state only.
REQ-023 SHALL keep fifoCount unchanged on a simultaneous push and pop (FIFO not full); read/write pointers SHALL wrap modulo FifoDepth.
REQ-024 SHALL NOT pass a byte through when the FIFO is full, even if a pop occurs on the same edge; dataReady stays 0 that cycle.
REQ-025 SHALL drive tx=1 whenever in IDLE.
REQ-026 SHALL drive busy=1 iff state != IDLE or fifoCount != 0.
REQ-027 SHALL latch data into the FIFO on acceptance; later changes to data SHALL NOT affect queued or in-flight bytes.

Reset
REQ-028 SHALL, on any edge with reset=1, set tx=1, state=IDLE, fifoCount=0, both pointers 0, and the tick and bit counters 0; busy=0 and dataReady=1 after that edge.
REQ-029 SHALL discard dataValid in any cycle with reset=1.
REQ-030 SHALL, on reset mid-frame, abort the frame: tx returns high at that edge, queued bytes are flushed, and no partial frame resumes.

Verification (bench: ClockFrequency=1000000, BaudRate=100000, BitTicks=10)
REQ-031 SHALL verify: push 0x55 while idle -> tx low from the next edge, then 1,0,1,0,1,0,1,0 in 10-cycle bits, then 10 cycles high; busy falls after cycle 100.
REQ-032 SHALL verify: push 0xA5 then 0x3C on consecutive cycles -> 200 contiguous frame cycles with the second start bit directly after the first stop bit; LSB-first data matches.
REQ-033 SHALL verify: dataValid held high with 0x00..0x05 during a slow drain (FifoDepth=4) -> 5 bytes accepted, dataReady=0 with fifoCount=4, 6th byte accepted only after the first frame's pop frees a slot; all 6 frames sent in order.
REQ-034 SHALL verify: reset asserted at cycle 35 of the first frame with 2 bytes queued -> after that edge tx=1, busy=0, fifoCount=0, and tx stays high for 200 cycles.
REQ-035 SHALL verify: StopBits=2, push 0xFF -> 110-cycle frame, tx low only during the first 10 cycles.
REQ-036 SHALL verify: simultaneous push and pop at fifoCount=2 -> fifoCount stays 2, and pointer wrap is exercised over 10 consecutive bytes with no loss or reordering.
